// File: rtl/demapper_4_ask_ref.sv
// 4-ASK slicer with adaptive reference tracking: Gray symbol, ideal level and slicer error.
// SLICER_ERR_OUT_EN enables the saturated error output; when undefined err_out is held at 0.
//
// state   | meaning
// ACQUIRE | no window completed yet, ref_level = INIT_REF, locked = 0
// TRACK   | ref_level follows each completed window mean, locked = 1
module demapper_4_ask_ref #(
  parameter int                 LOG2_N   = 10,
  parameter logic signed [17:0] INIT_REF = 18'sd32768
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clk_en,
  input  logic signed [17:0] sig_in,
  input  logic               hold,
  output logic [1:0]         data_out,
  output logic signed [17:0] dec_level,
  output logic signed [17:0] err_out,
  output logic signed [17:0] ref_level,
  output logic               locked,
  output logic               valid
);

  localparam int ACC_W = 17 + LOG2_N;

  typedef enum logic {ACQUIRE, TRACK} state_t;
  state_t state_q, state_d;

  logic signed [17:0] x_r;
  logic [16:0]        ax_r;
  logic               stage1_vld;
  logic [ACC_W-1:0]   acc;
  logic [LOG2_N-1:0]  cnt;

  logic signed [17:0] neg_in;
  logic [16:0]        ax_in;
  logic signed [17:0] p1, p2;
  logic signed [18:0] p2_raw;
  logic [1:0]         sym;
  logic signed [17:0] lvl;
  logic signed [17:0] err_c;
  logic [ACC_W-1:0]   acc_sum;
  logic signed [17:0] ref_new;
  logic               win_end;

  assign neg_in = -sig_in;
  // -131072 has no positive 1s17 counterpart, so its magnitude clamps to full scale
  assign ax_in  = (sig_in == 18'sh20000) ? 17'h1ffff :
                  (sig_in[17] ? neg_in[16:0] : sig_in[16:0]);

  assign p1     = ref_level >>> 1;
  assign p2_raw = {ref_level[17], ref_level} + {p1[17], p1};
  assign p2     = (p2_raw > 19'sd131071) ? 18'sd131071 : p2_raw[17:0];

  always_comb begin
    sym = 2'b00;
    lvl = '0;
    if (x_r >= ref_level) begin
      sym = 2'b00;
      lvl = p2;
    end else if (x_r >= 18'sd0) begin
      sym = 2'b01;
      lvl = p1;
    end else if (x_r >= -ref_level) begin
      sym = 2'b11;
      lvl = -p1;
    end else begin
      sym = 2'b10;
      lvl = -p2;
    end
  end

`ifdef SLICER_ERR_OUT_EN
  logic signed [18:0] diff;
  always_comb begin
    diff  = {x_r[17], x_r} - {lvl[17], lvl};
    err_c = diff[17:0];
    if (diff > 19'sd131071)
      err_c = 18'sd131071;
    else if (diff < -19'sd131072)
      err_c = -18'sd131072;
  end
`else
  assign err_c = '0;
`endif

  assign acc_sum = acc + {{LOG2_N{1'b0}}, ax_r};
  // window mean of 17-bit magnitudes always fits in 17 bits, so ref stays non-negative
  assign ref_new = {1'b0, acc_sum[LOG2_N +: 17]};
  assign win_end = stage1_vld && !hold && (cnt == '1);

  always_comb begin
    state_d = state_q;
    if (clk_en && win_end)
      state_d = TRACK;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      state_q <= ACQUIRE;
    else
      state_q <= state_d;
  end

  assign locked = (state_q == TRACK);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_r        <= '0;
      ax_r       <= '0;
      stage1_vld <= 1'b0;
      valid      <= 1'b0;
      data_out   <= 2'b00;
      dec_level  <= '0;
      err_out    <= '0;
      acc        <= '0;
      cnt        <= '0;
      ref_level  <= INIT_REF;
    end else if (clk_en) begin
      x_r        <= sig_in;
      ax_r       <= ax_in;
      stage1_vld <= 1'b1;
      valid      <= stage1_vld;
      data_out   <= sym;
      dec_level  <= lvl;
      err_out    <= err_c;
      if (hold) begin
        acc <= '0;
        cnt <= '0;
      end else if (stage1_vld) begin
        if (cnt == '1) begin
          acc       <= '0;
          cnt       <= '0;
          ref_level <= ref_new;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_demapper_4_ask_ref.sv
// Scoreboard bench for demapper_4_ask_ref: driver pushes model results, monitor pops on each output.
module tb_demapper_4_ask_ref;

  localparam int LOG2_N = 4;
  localparam int WIN    = 16;
  localparam int INIT_R = 32768;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic               clk_en = 1'b0;
  logic               hold = 1'b0;
  logic signed [17:0] sig_in = '0;
  logic [1:0]         data_out;
  logic signed [17:0] dec_level, err_out, ref_level;
  logic               locked, valid;

  demapper_4_ask_ref #(.LOG2_N(LOG2_N), .INIT_REF(18'sd32768)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .sig_in(sig_in), .hold(hold),
    .data_out(data_out), .dec_level(dec_level), .err_out(err_out),
    .ref_level(ref_level), .locked(locked), .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct {int d; int lvl; int err; int r; bit lk;} exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  bit   have_last = 0;
  int   n_cmp = 0, n_bad = 0;

  int   m_r = INIT_R;
  bit   m_lk = 0;
  int   mags[$];
  bit   have_prev = 0;
  int   prev_x = 0;
  bit   mon_en, mon_rs;

  function automatic int sat18(int v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  function automatic int mag(int x);
    if (x == -131072) return 131071;
    return (x < 0) ? -x : x;
  endfunction

  function automatic exp_t model_slice(int x, int r);
    exp_t e;
    int p1 = r / 2;
    int p2 = r + r / 2;
    if (p2 > 131071) p2 = 131071;
    if (x >= r)       begin e.d = 0; e.lvl = p2;  end
    else if (x >= 0)  begin e.d = 1; e.lvl = p1;  end
    else if (x >= -r) begin e.d = 3; e.lvl = -p1; end
    else              begin e.d = 2; e.lvl = -p2; end
`ifdef SLICER_ERR_OUT_EN
    e.err = sat18(x - e.lvl);
`else
    e.err = 0;
`endif
    e.r  = r;
    e.lk = 0;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic compare_out(input string tag, input exp_t e);
    check({tag, ".data_out"},  int'(data_out), e.d);
    check({tag, ".dec_level"}, int'(dec_level), e.lvl);
    check({tag, ".err_out"},   int'(err_out), e.err);
    check({tag, ".ref_level"}, int'(ref_level), e.r);
    check({tag, ".locked"},    int'(locked), int'(e.lk));
  endtask

  // Monitor: a strobe with valid high consumes one expected result; idle edges must not move outputs.
  always @(posedge clk) begin
    mon_en = clk_en;
    mon_rs = reset_n;
    #1;
    if (mon_rs && valid) begin
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got valid=1, expected no pending result");
        end else begin
          last_exp  = exp_q.pop_front();
          have_last = 1;
          compare_out("out", last_exp);
        end
      end else if (have_last) begin
        compare_out("gap", last_exp);
      end
    end
  end

  task automatic strobe(input int s, input bit h);
    exp_t e;
    int   sum;
    @(negedge clk);
    sig_in = 18'(s);
    hold   = h;
    clk_en = 1'b1;
    if (have_prev) begin
      e = model_slice(prev_x, m_r);
      if (h) begin
        mags.delete();
      end else begin
        mags.push_back(mag(prev_x));
        if (mags.size() == WIN) begin
          sum = 0;
          foreach (mags[i]) sum += mags[i];
          m_r  = sum / WIN;
          m_lk = 1;
          mags.delete();
        end
      end
      e.r  = m_r;
      e.lk = m_lk;
      exp_q.push_back(e);
    end
    prev_x    = s;
    have_prev = 1;
    @(posedge clk);
    #1;
    clk_en = 1'b0;
    hold   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check("drain_before_reset", exp_q.size(), 0);
    reset_n = 1'b0;
    clk_en  = 1'($urandom_range(0, 1));
    sig_in  = 18'($urandom);
    @(posedge clk);
    #2;
    check("rst.ref_level", int'(ref_level), INIT_R);
    check("rst.locked",    int'(locked), 0);
    check("rst.valid",     int'(valid), 0);
    check("rst.data_out",  int'(data_out), 0);
    check("rst.dec_level", int'(dec_level), 0);
    check("rst.err_out",   int'(err_out), 0);
    @(negedge clk);
    reset_n = 1'b1;
    clk_en  = 1'b0;
    exp_q.delete();
    mags.delete();
    m_r       = INIT_R;
    m_lk      = 0;
    have_prev = 0;
  endtask

  initial begin
    int pts[4];
    int s;
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int amp[4];
    int s;
    amp[0] = 60000; amp[1] = 20000; amp[2] = -20000; amp[3] = -60000;

    do_reset();
    strobe(32768, 0);
    check("valid_after_1_strobe", int'(valid), 0);
    strobe(32767, 0);
    check("valid_after_2_strobes", int'(valid), 1);
    strobe(0, 0);
    strobe(-1, 0);
    strobe(-32768, 0);
    strobe(-32769, 0);
    strobe(0, 0);

    // acquisition, with an idle gap mid-stream
    do_reset();
    for (int i = 0; i < 16; i++) begin
      strobe(amp[i % 4], 0);
      if (i == 7) idle(10);
    end
    check("acq.locked_before", int'(locked), 0);
    strobe(0, 0);
    check("acq.ref_level", int'(ref_level), 40000);
    check("acq.locked", int'(locked), 1);

    // hold discards a partial window
    do_reset();
    for (int i = 0; i < 8; i++) strobe(amp[i % 4], 0);
    strobe(50000, 1);
    for (int i = 0; i < 15; i++) strobe(50000, 0);
    check("hold.locked_before", int'(locked), 0);
    check("hold.ref_level_before", int'(ref_level), INIT_R);
    strobe(50000, 0);
    check("hold.locked", int'(locked), 1);
    check("hold.ref_level", int'(ref_level), 50000);

    // saturation at full scale
    do_reset();
    for (int i = 0; i < 16; i++) strobe(-131072, 0);
    strobe(131071, 0);
    check("sat.ref_level", int'(ref_level), 131071);
    strobe(-131072, 0);
    strobe(0, 0);

    // reset mid-window after lock
    for (int i = 0; i < 5; i++) strobe(int'($urandom_range(0, 262143)) - 131072, 0);
    do_reset();
    for (int i = 0; i < 16; i++) strobe((i % 2) ? 24000 : -24000, 0);
    check("rst_mid.locked_before", int'(locked), 0);
    strobe(0, 0);
    check("rst_mid.ref_level", int'(ref_level), 24000);
    check("rst_mid.locked", int'(locked), 1);

    // randomized stream: constellation points with noise, raw full-range samples, gaps, holds
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      case ($urandom_range(0, 3))
        0: s = int'($urandom_range(0, 262143)) - 131072;
        default: s = sat18(amp[$urandom_range(0, 3)] + int'($urandom_range(0, 4000)) - 2000);
      endcase
      strobe(s, ($urandom_range(0, 99) < 3));
      if ($urandom_range(0, 9) < 3) idle(int'($urandom_range(1, 4)));
    end

    idle(3);
    check("drain_end", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
